// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit:
//   - funct3 access size / sign encodings
//   - FSM state encoding (also exported on the debug state port)
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

endpackage

// File: rtl/defines.sv
// Shared width macros for the memory access unit.
//   REG_BUS : bit range of an architectural register / data bus word.
`ifndef MEM_ACCESS_UNIT_DEFINES_SV
`define MEM_ACCESS_UNIT_DEFINES_SV

`define REG_BUS 31:0

`endif

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the memory access unit.
// Request side (live DM-stage inputs):
//   req_funct3_i, req_off_i, req_data_i -> req_legal_o (size legal and aligned),
//   st_wstrb_o / st_wdata_o (store lanes steered to the addressed bytes).
// Load side (latched access kind):
//   ld_funct3_i, ld_off_i, ld_rdata_i  -> ld_data_o (selected and extended word).
`include "defines.sv"

module mem_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]        req_funct3_i,
    input  logic [1:0]        req_off_i,
    input  logic [`REG_BUS]   req_data_i,
    output logic              req_legal_o,
    output logic [3:0]        st_wstrb_o,
    output logic [31:0]       st_wdata_o,
    input  logic [2:0]        ld_funct3_i,
    input  logic [1:0]        ld_off_i,
    input  logic [31:0]       ld_rdata_i,
    output logic [`REG_BUS]   ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store steering: data is replicated across the word so that whichever
    // lanes the strobe enables already carry the right bytes.
    always_comb begin
        req_legal_o = 1'b0;
        st_wstrb_o  = 4'b0000;
        st_wdata_o  = 32'h0;
        case (req_funct3_i)
            F3_B, F3_BU: begin
                req_legal_o = 1'b1;
                st_wstrb_o  = 4'b0001 << req_off_i;
                st_wdata_o  = {4{req_data_i[7:0]}};
            end
            F3_H, F3_HU: begin
                req_legal_o = ~req_off_i[0];
                st_wstrb_o  = 4'b0011 << req_off_i;
                st_wdata_o  = {2{req_data_i[15:0]}};
            end
            F3_W: begin
                req_legal_o = (req_off_i == 2'b00);
                st_wstrb_o  = 4'b1111;
                st_wdata_o  = req_data_i;
            end
            default: begin
                req_legal_o = 1'b0;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (ld_off_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        // Halfword loads are always 2-byte aligned, so only addr[1] matters.
        ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

        ld_data_o = ld_rdata_i;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'h0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'h0, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// DM-stage memory access unit: turns a load/store from the pipeline into a
// single request on the data-memory bus and returns the extended load data.
// Ports:
//   clk, reset (async, active low)
//   m_valid, m_mem_read, m_mem_write, m_funct3, m_alu_y, m_rrd2 : DM-stage instruction
//   dm_req_valid/ready, dm_req_we/addr/wdata/wstrb               : request channel
//   dm_resp_valid, dm_resp_rdata                                 : read response (always accepted)
//   stall                                                        : holds EX/DM and DM/WB registers
//   m_load_data, load_done, store_done, access_fault             : completion / status
//   dbg_state                                                    : current FSM state
//
// Request handshake: dm_req_valid rises in REQ and stays high with addr, we,
// wdata and wstrb unchanged until the first cycle in which dm_req_ready is also
// high; the transfer happens on that clock edge. There is no response
// back-pressure: dm_resp_valid is taken only in WAIT_RESP, ignored elsewhere.
`include "defines.sv"

module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              m_mem_read,
    input  logic              m_mem_write,
    input  logic [2:0]        m_funct3,
    input  logic [`REG_BUS]   m_alu_y,
    input  logic [`REG_BUS]   m_rrd2,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic              dm_req_we,
    output logic [31:0]       dm_req_addr,
    output logic [31:0]       dm_req_wdata,
    output logic [3:0]        dm_req_wstrb,
    input  logic              dm_resp_valid,
    input  logic [31:0]       dm_resp_rdata,
    output logic              stall,
    output logic [`REG_BUS]   m_load_data,
    output logic              load_done,
    output logic              store_done,
    output logic              access_fault,
    output state_e            dbg_state
);

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            we_q, we_d;
    logic [2:0]      ld_funct3_q, ld_funct3_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic [`REG_BUS] load_data_q, load_data_d;

    logic            req_legal;
    logic [3:0]      st_wstrb;
    logic [31:0]     st_wdata;
    logic [`REG_BUS] ld_data;
    logic            one_op;
    logic            any_op;
    logic            accept;
    logic            fault;

    mem_align u_align (
        .req_funct3_i (m_funct3),
        .req_off_i    (m_alu_y[1:0]),
        .req_data_i   (m_rrd2),
        .req_legal_o  (req_legal),
        .st_wstrb_o   (st_wstrb),
        .st_wdata_o   (st_wdata),
        .ld_funct3_i  (ld_funct3_q),
        .ld_off_i     (ld_off_q),
        .ld_rdata_i   (dm_resp_rdata),
        .ld_data_o    (ld_data)
    );

    // Only IDLE looks at the pipeline; while busy the stalled instruction is
    // still presented on the inputs and must not be taken a second time.
    assign one_op = m_mem_read ^ m_mem_write;
    assign any_op = m_mem_read | m_mem_write;
    assign accept = (state_q == ST_IDLE) && m_valid && one_op && req_legal;
    assign fault  = (state_q == ST_IDLE) && m_valid && any_op && !(one_op && req_legal);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            we_q        <= 1'b0;
            ld_funct3_q <= 3'b000;
            ld_off_q    <= 2'b00;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            we_q        <= we_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        we_d        = we_q;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        load_data_d = load_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_REQ;
                    addr_d      = {m_alu_y[31:2], 2'b00};
                    we_d        = m_mem_write;
                    wdata_d     = m_mem_write ? st_wdata : 32'h0;
                    wstrb_d     = m_mem_write ? st_wstrb : 4'b0000;
                    ld_funct3_d = m_funct3;
                    ld_off_d    = m_alu_y[1:0];
                end
            end
            ST_REQ: begin
                if (dm_req_ready) begin
                    state_d = we_q ? ST_DONE : ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (dm_resp_valid) begin
                    load_data_d = ld_data;
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dm_req_valid = (state_q == ST_REQ);
    assign dm_req_we    = we_q;
    assign dm_req_addr  = addr_q;
    assign dm_req_wdata = wdata_q;
    assign dm_req_wstrb = wstrb_q;
    assign stall        = (state_q == ST_REQ) || (state_q == ST_WAIT_RESP) || accept;
    assign m_load_data  = load_data_q;
    assign load_done    = (state_q == ST_DONE) && !we_q;
    assign store_done   = (state_q == ST_DONE) && we_q;
    assign access_fault = fault;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m_valid, m_mem_read, m_mem_write;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_y, m_rrd2;
  logic        dm_req_valid, dm_req_ready, dm_req_we;
  logic [31:0] dm_req_addr, dm_req_wdata;
  logic [3:0]  dm_req_wstrb;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_rdata;
  logic        stall;
  logic [31:0] m_load_data;
  logic        load_done, store_done, access_fault;
  state_e      dbg_state;

  mem_access_unit dut (
    .clk           (clk),
    .reset         (reset),
    .m_valid       (m_valid),
    .m_mem_read    (m_mem_read),
    .m_mem_write   (m_mem_write),
    .m_funct3      (m_funct3),
    .m_alu_y       (m_alu_y),
    .m_rrd2        (m_rrd2),
    .dm_req_valid  (dm_req_valid),
    .dm_req_ready  (dm_req_ready),
    .dm_req_we     (dm_req_we),
    .dm_req_addr   (dm_req_addr),
    .dm_req_wdata  (dm_req_wdata),
    .dm_req_wstrb  (dm_req_wstrb),
    .dm_resp_valid (dm_resp_valid),
    .dm_resp_rdata (dm_resp_rdata),
    .stall         (stall),
    .m_load_data   (m_load_data),
    .load_done     (load_done),
    .store_done    (store_done),
    .access_fault  (access_fault),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  // kind: {load, store, fault} one-hot, same order as the DUT flags
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  logic [31:0] exp_hold;
  int          errors = 0;
  int          checks = 0;

  // responder configuration
  logic        auto_resp;
  int          cfg_rdy, cfg_rsp;
  logic [31:0] cfg_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic legal(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd == wr) return 1'b0;
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return (a % 2) == 0;
      3'b010:         return (a % 4) == 0;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s = 4'b0000;
    int off = int'(a % 4);
    for (int i = 0; i < nbytes(f3); i++) s[off + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] v = rdata >> (8 * (a % 4));
    int n = nbytes(f3);
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (f3[2] == 1'b0 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'h0000_FFFF;
      if (f3[2] == 1'b0 && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after a falling edge.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int rdy, input int rsp, input logic [31:0] rdata);
    int exp_stall = 0;
    int n = 0;
    req_t r;
    done_t e;
    if (legal(rd, wr, f3, a)) begin
      r.addr  = a & 32'hFFFF_FFFC;
      r.we    = wr;
      r.wdata = wr ? model_wdata(f3, d) : 32'h0;
      r.wstrb = wr ? model_strb(f3, a) : 4'b0000;
      req_q.push_back(r);
      e.kind = wr ? 3'b010 : 3'b100;
      e.data = wr ? 32'h0 : model_load(f3, a, rdata);
      done_q.push_back(e);
      exp_stall = wr ? (2 + rdy) : (3 + rdy + rsp);
    end else if (rd || wr) begin
      e.kind = 3'b001;
      e.data = 32'h0;
      done_q.push_back(e);
    end
    cfg_rdy     = rdy;
    cfg_rsp     = rsp;
    cfg_rdata   = rdata;
    m_valid     = 1'b1;
    m_mem_read  = rd;
    m_mem_write = wr;
    m_funct3    = f3;
    m_alu_y     = a;
    m_rrd2      = d;
    #1;
    while (stall && n < 300) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", n, exp_stall);
    @(negedge clk);
    m_valid     = 1'b0;
    m_mem_read  = 1'b0;
    m_mem_write = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    int  rcnt = 0;
    int  pcnt = 0;
    logic pend = 1'b0;
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    dm_resp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!auto_resp || !reset) begin
        rcnt = 0;
        pend = 1'b0;
        if (auto_resp) begin
          dm_req_ready  = 1'b0;
          dm_resp_valid = 1'b0;
        end
      end else begin
        dm_req_ready  = 1'b0;
        dm_resp_valid = 1'b0;
        dm_resp_rdata = $urandom;
        if (dm_req_valid) begin
          if (rcnt >= cfg_rdy) begin
            dm_req_ready = 1'b1;
            rcnt = 0;
            pend = !dm_req_we;
            pcnt = 0;
          end else begin
            rcnt++;
          end
          // stray response while the request is still pending: must be ignored
          if ($urandom_range(0, 3) == 0) dm_resp_valid = 1'b1;
        end else if (pend) begin
          if (pcnt >= cfg_rsp) begin
            dm_resp_valid = 1'b1;
            dm_resp_rdata = cfg_rdata;
            pend = 1'b0;
          end else begin
            pcnt++;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          dm_resp_valid = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    req_t  r;
    done_t d;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        if (dm_req_valid) begin
          if (req_q.size() == 0) begin
            check("req_unexpected", 32'(dm_req_valid), 32'h0);
          end else begin
            r = req_q[0];
            check("req_addr", dm_req_addr, r.addr);
            check("req_we", 32'(dm_req_we), 32'(r.we));
            check("req_wstrb", 32'(dm_req_wstrb), 32'(r.wstrb));
            if (r.we) check("req_wdata", dm_req_wdata, r.wdata);
            if (dm_req_ready) void'(req_q.pop_front());
          end
        end
        if (load_done || store_done || access_fault) begin
          if (done_q.size() == 0) begin
            check("done_unexpected", {29'h0, load_done, store_done, access_fault}, 32'h0);
          end else begin
            d = done_q.pop_front();
            check("done_kind", {29'h0, load_done, store_done, access_fault}, 32'(d.kind));
            if (d.kind == 3'b100) exp_hold = d.data;
            if (d.kind == 3'b001) begin
              check("fault_no_req", 32'(dm_req_valid), 32'h0);
              check("fault_no_stall", 32'(stall), 32'h0);
            end
          end
        end
        check("load_data", m_load_data, exp_hold);
      end
    end
  end

  // ---------------- reset output check ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(dm_req_valid), 32'h0);
    check({tag, "_req_we"}, 32'(dm_req_we), 32'h0);
    check({tag, "_stall"}, 32'(stall), 32'h0);
    check({tag, "_done_flags"}, {29'h0, load_done, store_done, access_fault}, 32'h0);
    check({tag, "_req_addr"}, dm_req_addr, 32'h0);
    check({tag, "_req_wdata"}, dm_req_wdata, 32'h0);
    check({tag, "_req_wstrb"}, 32'(dm_req_wstrb), 32'h0);
    check({tag, "_load_data"}, m_load_data, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

    reset       = 1'b0;
    auto_resp   = 1'b1;
    cfg_rdy     = 0;
    cfg_rsp     = 0;
    cfg_rdata   = 32'h0;
    exp_hold    = 32'h0;
    m_valid     = 1'b0;
    m_mem_read  = 1'b0;
    m_mem_write = 1'b0;
    m_funct3    = 3'b000;
    m_alu_y     = 32'h0;
    m_rrd2      = 32'h0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // directed cases
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);      // SW
    issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0);      // SB lane 3
    issue(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 0, 0, 32'h12F43456);      // LB -> FFFFFFF4
    issue(1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 0, 0, 32'h12F43456);      // LBU -> 000000F4
    issue(1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 0, 0, 32'h0);             // LH misaligned
    issue(1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0);             // read+write
    issue(1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 0, 0, 32'h0);             // bad funct3
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 4, 2, 32'hCAFEF00D);      // LW slow memory
    issue(1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 1, 1, 32'h8001_7FFF);     // LHU upper half
    issue(1'b0, 1'b1, 3'b001, 32'h502, 32'h0000_1234, 2, 0, 32'h0);     // SH upper half

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int sel = $urandom_range(0, 9);
      rd = 1'b0;
      wr = 1'b0;
      if (sel < 4) rd = 1'b1;
      else if (sel < 8) wr = 1'b1;
      else if (sel == 8) begin rd = 1'b1; wr = 1'b1; end
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(nbytes(f3)) - 32'h1);
      issue(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset while waiting for a load response, then a late response
    auto_resp = 1'b0;
    begin
      req_t r;
      r.addr = 32'h0000_0600; r.we = 1'b0; r.wdata = 32'h0; r.wstrb = 4'b0000;
      req_q.push_back(r);
    end
    m_valid = 1'b1; m_mem_read = 1'b1; m_mem_write = 1'b0;
    m_funct3 = 3'b010; m_alu_y = 32'h0000_0600;
    dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
    @(negedge clk);                       // REQ
    dm_req_ready = 1'b1;
    @(negedge clk);                       // WAIT_RESP
    dm_req_ready = 1'b0;
    #1;
    check("wait_stall", 32'(stall), 32'h1);
    reset = 1'b0;
    m_valid = 1'b0; m_mem_read = 1'b0;
    exp_hold = 32'h0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dm_resp_valid = 1'b1;
    dm_resp_rdata = 32'h1234_5678;
    @(negedge clk);
    dm_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("late");

    check("req_q_empty", 32'(req_q.size()), 32'h0);
    check("done_q_empty", 32'(done_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
